// File: rtl/rv32im_dmem_pkg.sv
// Shared definitions for the rv32im data memory slice.
// Holds the bus widths, the FSM state encodings, the captured-request record
// and the store-data lane steering helper.
package rv32im_dmem_pkg;

  localparam int API_DATA_WIDTH = 32;
  localparam int API_ADDR_WIDTH = 32;

  localparam logic [1:0] DMEM_ST_IDLE = 2'd0;
  localparam logic [1:0] DMEM_ST_WAIT = 2'd1;
  localparam logic [1:0] DMEM_ST_RESP = 2'd2;

  // Request as captured in IDLE; later input changes never reach it.
  typedef struct packed {
    logic [API_ADDR_WIDTH-1:0] addr;
    logic [3:0]                mask;
    logic [API_DATA_WIDTH-1:0] data;
  } dmem_req_t;

  // Store data arrives low-justified. Replicate it so that every lane a mask
  // can select sees the right source byte: single-byte masks take byte 0,
  // the upper-half mask takes the low halfword, everything else is byte i.
  function automatic logic [API_DATA_WIDTH-1:0] steer_wdata(
    input logic [3:0]                mask,
    input logic [API_DATA_WIDTH-1:0] data
  );
    case (mask)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return {4{data[7:0]}};
      4'b1100:                            return {2{data[15:0]}};
      default:                            return data;
    endcase
  endfunction

endpackage

// File: rtl/rv32im_dmem_array.sv
// Word storage for the data memory: DEPTH_WORDS words of four byte lanes.
// Ports:
//   clk     - clock, writes happen on the rising edge
//   wr_en   - per-lane write enables
//   idx     - word index shared by the write and the read port
//   wr_data - lane-aligned write data
//   rd_data - combinational read of the word at idx
// Contents are never reset.
module rv32im_dmem_array
  import rv32im_dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_WIDTH   = 10
) (
  input  logic                      clk,
  input  logic [3:0]                wr_en,
  input  logic [IDX_WIDTH-1:0]      idx,
  input  logic [API_DATA_WIDTH-1:0] wr_data,
  output logic [API_DATA_WIDTH-1:0] rd_data
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (wr_en[gi]) begin
        lane_mem[idx] <= wr_data[8*gi +: 8];
      end
    end

    assign rd_data[8*gi +: 8] = lane_mem[idx];
  end

endmodule

// File: rtl/rv32im_dmem.sv
// Data memory with a request/ready handshake and configurable wait states.
// Ports:
//   clk_i       - clock
//   rst_ni      - asynchronous active-low reset
//   enable_i    - request present, held until ready_o
//   addr_mem_i  - word address
//   wr_mask_i   - byte-lane write mask, 0000 is a read
//   val_memwr_i - low-justified store data
//   val_memrd_o - full read word, non-zero only in the response cycle
//   ready_o     - one-cycle response pulse
//   err_o       - out-of-range address flag, only with ready_o
module rv32im_dmem
  import rv32im_dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      enable_i,
  input  logic [API_ADDR_WIDTH-1:0] addr_mem_i,
  input  logic [3:0]                wr_mask_i,
  input  logic [API_DATA_WIDTH-1:0] val_memwr_i,
  output logic [API_DATA_WIDTH-1:0] val_memrd_o,
  output logic                      ready_o,
  output logic                      err_o
);

  localparam int IDX_WIDTH = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LAST = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam logic [API_ADDR_WIDTH-1:0] DEPTH_LIMIT = API_ADDR_WIDTH'(DEPTH_WORDS);

  logic [1:0]                state_reg, state_next;
  logic [3:0]                cnt_reg, cnt_next;
  dmem_req_t                 req_reg, req_next;
  logic                      is_resp;
  logic                      in_range;
  logic [3:0]                lane_we;
  logic [API_DATA_WIDTH-1:0] arr_rdata;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= DMEM_ST_IDLE;
      cnt_reg   <= '0;
      req_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      req_reg   <= req_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    req_next   = req_reg;
    case (state_reg)
      DMEM_ST_IDLE: begin
        if (enable_i) begin
          req_next.addr = addr_mem_i;
          req_next.mask = wr_mask_i;
          req_next.data = val_memwr_i;
          cnt_next      = '0;
          state_next    = (WAIT_STATES > 0) ? DMEM_ST_WAIT : DMEM_ST_RESP;
        end
      end
      DMEM_ST_WAIT: begin
        // A requester that lets go mid-wait abandons the request entirely.
        if (!enable_i) begin
          state_next = DMEM_ST_IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == WAIT_LAST) begin
          state_next = DMEM_ST_RESP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      DMEM_ST_RESP: begin
        state_next = DMEM_ST_IDLE;
      end
      default: begin
        state_next = DMEM_ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign is_resp  = (state_reg == DMEM_ST_RESP);
  assign in_range = (req_reg.addr < DEPTH_LIMIT);

  // Writes land on the edge that closes the response cycle, so a reset
  // arriving during any earlier cycle leaves the array untouched.
  assign lane_we = (is_resp && in_range) ? req_reg.mask : 4'b0000;

  rv32im_dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_WIDTH   (IDX_WIDTH)
  ) u_array (
    .clk     (clk_i),
    .wr_en   (lane_we),
    .idx     (req_reg.addr[IDX_WIDTH-1:0]),
    .wr_data (steer_wdata(req_reg.mask, req_reg.data)),
    .rd_data (arr_rdata)
  );

  assign ready_o     = is_resp;
  assign err_o       = is_resp && !in_range;
  assign val_memrd_o = (is_resp && in_range && (req_reg.mask == 4'b0000)) ? arr_rdata : '0;

endmodule
